// File: rtl/coef_ram_loader.sv
// coef_ram_loader: host-side writer for the dual-channel coefficient RAM.
// Accepts a load command (channel, start address, word count), streams
// DATA_W-bit coefficients from a valid/ready input into the selected RAM
// read/write port at one word per cycle, and optionally reads the block back
// and compares checksums.
//
// Optional feature: define COEF_RAM_LOADER_VERIFY_EN to build the readback
// states and the write/read checksums. Without it, WRITE goes straight to
// FINISH and err reports only a zero-length command.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready       load command handshake (ready only in IDLE)
//   cmd_chan, cmd_addr, cmd_len  channel (0=L,1=R), start address, word count
//   din_valid/din_ready, din  coefficient stream (ready only in WRITE)
//   addrLrw/addrRrw, datainLrw/datainRrw, weL/weR  RAM rw port drive
//   dataoutLrw/dataoutRrw     RAM read data (registered in the RAM)
//   busy, done, err           status: not idle, finish pulse, sticky error
module coef_ram_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 36
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_chan,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] addrLrw,
  output logic [ADDR_W-1:0] addrRrw,
  output logic [DATA_W-1:0] datainLrw,
  output logic [DATA_W-1:0] datainRrw,
  output logic              weL,
  output logic              weR,
  input  logic [DATA_W-1:0] dataoutLrw,
  input  logic [DATA_W-1:0] dataoutRrw,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t             state;
  logic               chan;
  logic [ADDR_W-1:0]  curAddr;
  logic [LEN_W-1:0]   remaining;

`ifdef COEF_RAM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0]  startAddr;
  logic [LEN_W-1:0]   lenQ;
  logic [DATA_W-1:0]  wrSum;
  logic [DATA_W-1:0]  rdSum;
  logic [DATA_W-1:0]  rdWord;

  // Read data from the channel being verified.
  assign rdWord = chan ? dataoutRrw : dataoutLrw;
`else
  logic unusedDataout;
  assign unusedDataout = ^{dataoutLrw, dataoutRrw};
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      chan      <= 1'b0;
      curAddr   <= '0;
      remaining <= '0;
      cmd_ready <= 1'b0;
      din_ready <= 1'b0;
      addrLrw   <= '0;
      addrRrw   <= '0;
      datainLrw <= '0;
      datainRrw <= '0;
      weL       <= 1'b0;
      weR       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef COEF_RAM_LOADER_VERIFY_EN
      startAddr <= '0;
      lenQ      <= '0;
      wrSum     <= '0;
      rdSum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            chan      <= cmd_chan;
            curAddr   <= cmd_addr;
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            err       <= (cmd_len == '0);
            addrLrw   <= '0;
            addrRrw   <= '0;
            datainLrw <= '0;
            datainRrw <= '0;
`ifdef COEF_RAM_LOADER_VERIFY_EN
            startAddr <= cmd_addr;
            lenQ      <= cmd_len;
            wrSum     <= '0;
            rdSum     <= '0;
`endif
            if (cmd_len == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state     <= WRITE;
              din_ready <= 1'b1;
            end
          end
        end

        WRITE: begin
          // No handshake: write enable drops, address/data hold.
          weL <= 1'b0;
          weR <= 1'b0;
          if (din_valid && din_ready) begin
            weL       <= ~chan;
            weR       <= chan;
            addrLrw   <= chan ? '0 : curAddr;
            addrRrw   <= chan ? curAddr : '0;
            datainLrw <= chan ? '0 : din;
            datainRrw <= chan ? din : '0;
            curAddr   <= curAddr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
`ifdef COEF_RAM_LOADER_VERIFY_EN
            wrSum     <= wrSum + din;
`endif
            if (remaining == LEN_W'(1)) begin
              din_ready <= 1'b0;
`ifndef COEF_RAM_LOADER_VERIFY_EN
              state     <= FINISH;
              done      <= 1'b1;
`endif
            end
          end
`ifdef COEF_RAM_LOADER_VERIFY_EN
          // Last word was taken on the previous edge; its RAM write lands now.
          else if (!din_ready) begin
            state     <= RD_ADDR;
            curAddr   <= startAddr;
            remaining <= lenQ;
            if (chan) addrRrw <= startAddr;
            else      addrLrw <= startAddr;
          end
`endif
        end

`ifdef COEF_RAM_LOADER_VERIFY_EN
        RD_ADDR: begin
          state <= RD_DATA;
        end

        RD_DATA: begin
          rdSum     <= rdSum + rdWord;
          curAddr   <= curAddr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (chan) addrRrw <= curAddr + ADDR_W'(1);
          else      addrLrw <= curAddr + ADDR_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= FINISH;
            done  <= 1'b1;
            if ((rdSum + rdWord) != wrSum) err <= 1'b1;
          end else begin
            state <= RD_ADDR;
          end
        end
`endif

        FINISH: begin
          weL       <= 1'b0;
          weR       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coef_ram_loader.sv
// Self-checking bench for coef_ram_loader with a behavioural RAM model,
// an expected-write queue, and directed load scenarios.
module tb_coef_ram_loader;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef COEF_RAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_chan;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addrLrw, addrRrw;
  logic [DATA_W-1:0] datainLrw, datainRrw;
  logic              weL, weR;
  logic [DATA_W-1:0] dataoutLrw, dataoutRrw;
  logic              busy, done, err;

  typedef struct packed {
    logic              chan;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               expQ[$];
  int                nTests = 0;
  int                nFail = 0;
  int                weCycles = 0;
  int                doneCount = 0;
  int                ramWrites = 0;
  logic [DATA_W-1:0] words [0:7];
  logic [DATA_W-1:0] ramL [0:DEPTH-1];
  logic [DATA_W-1:0] ramR [0:DEPTH-1];
  logic              corruptEn;
  logic [ADDR_W-1:0] corruptAddr;
  logic              errSeen;

  coef_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_chan   (cmd_chan),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .addrLrw    (addrLrw),
    .addrRrw    (addrRrw),
    .datainLrw  (datainLrw),
    .datainRrw  (datainRrw),
    .weL        (weL),
    .weR        (weR),
    .dataoutLrw (dataoutLrw),
    .dataoutRrw (dataoutRrw),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Coefficient RAM model: synchronous write, registered read, optional bit flip.
  always @(posedge clock) begin
    if (weL) begin
      ramL[addrLrw] <= datainLrw;
      ramWrites <= ramWrites + 1;
    end else if (weR) begin
      ramR[addrRrw] <= datainRrw;
      ramWrites <= ramWrites + 1;
    end
    dataoutLrw <= ramL[addrLrw] ^ ((corruptEn && addrLrw == corruptAddr) ? DATA_W'(1) : DATA_W'(0));
    dataoutRrw <= ramR[addrRrw] ^ ((corruptEn && addrRrw == corruptAddr) ? DATA_W'(1) : DATA_W'(0));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every cycle: any write on the RAM port must be the next expected write.
  task automatic compareLoop();
    wr_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done) doneCount++;
        if (weL || weR) begin
          weCycles++;
          if (expQ.size() == 0) begin
            chk("unexpected_write", 64'({weL, weR}), 64'(0));
          end else begin
            e = expQ.pop_front();
            chk("write_enable", 64'({weL, weR}), 64'({~e.chan, e.chan}));
            chk("write_addr", 64'(e.chan ? addrRrw : addrLrw), 64'(e.addr));
            chk("write_data", 64'(e.chan ? datainRrw : datainLrw), 64'(e.data));
            chk("other_chan_zero", 64'(e.chan ? {addrLrw, datainLrw} : {addrRrw, datainRrw}), 64'(0));
          end
        end
      end
    end
  endtask

  task automatic acceptCmd(input logic ch, input int addr, input int len);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_chan  = ch;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(len);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    chk("busy_after_accept", 64'({busy, cmd_ready}), 64'(2'b10));
    chk("err_on_accept", 64'(err), 64'(len == 0));
    chk("din_ready_on_accept", 64'(din_ready), 64'(len != 0));
  endtask

  // Run one load; gap=1 drops din_valid every other cycle.
  task automatic doLoad(input logic ch, input int addr, input int len, input bit gap,
                        output logic errAtDone);
    int idx, k, lat, expLat;
    logic [ADDR_W-1:0] a;
    acceptCmd(ch, addr, len);
    a = ADDR_W'(addr);
    idx = 0;
    k = 0;
    while (idx < len && k < 200) begin
      din_valid = !gap || (k % 2 == 0);
      din = words[idx];
      if (din_valid && din_ready) begin
        expQ.push_back('{ch, a, din});
        a = a + ADDR_W'(1);
        idx++;
      end
      @(negedge clock);
      k++;
    end
    din_valid = 1'b0;
    chk("words_consumed", 64'(idx), 64'(len));
    expLat = (len == 0) ? 0 : (VERIFY ? 1 + 2 * len : 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(expLat));
    errAtDone = err;
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("idle_after_done", 64'({busy, cmd_ready}), 64'(2'b01));
    chk("queue_drained", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    int w0, d0, r0;
    clock = 1'b0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_chan = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    din_valid = 1'b0;
    din = '0;
    corruptEn = 1'b0;
    corruptAddr = '0;
    fork
      compareLoop();
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", 64'({cmd_ready, din_ready, busy, done, err, weL, weR}), 64'(0));
    chk("reset_addr", 64'({addrLrw, addrRrw}), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("cmd_ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));

    // Left load, addr 0, 4 words, continuous valid.
    for (int i = 0; i < 8; i++) words[i] = DATA_W'(i + 1);
    w0 = weCycles;
    doLoad(1'b0, 0, 4, 1'b0, errSeen);
    chk("t1_err", 64'(errSeen), 64'(0));
    chk("t1_write_cycles", 64'(weCycles - w0), 64'(4));
    for (int i = 0; i < 4; i++) chk("t1_ram", 64'(ramL[i]), 64'(i + 1));

    // Right load with address wrap.
    for (int i = 0; i < 4; i++) words[i] = 36'h9_0000_0000 + DATA_W'(i);
    doLoad(1'b1, 16382, 4, 1'b0, errSeen);
    chk("t2_err", 64'(errSeen), 64'(0));
    chk("t2_ram_16382", 64'(ramR[16382]), 64'(36'h9_0000_0000));
    chk("t2_ram_16383", 64'(ramR[16383]), 64'(36'h9_0000_0001));
    chk("t2_ram_0", 64'(ramR[0]), 64'(36'h9_0000_0002));
    chk("t2_ram_1", 64'(ramR[1]), 64'(36'h9_0000_0003));

    // Gapped valid, 3 words.
    for (int i = 0; i < 3; i++) words[i] = 36'hF_FFFF_FFF0 + DATA_W'(i);
    w0 = weCycles;
    doLoad(1'b0, 100, 3, 1'b1, errSeen);
    chk("t3_write_cycles", 64'(weCycles - w0), 64'(3));
    chk("t3_ram_100", 64'(ramL[100]), 64'(36'hF_FFFF_FFF0));
    chk("t3_ram_102", 64'(ramL[102]), 64'(36'hF_FFFF_FFF2));

    // din_valid held in IDLE is not consumed.
    w0 = weCycles;
    din_valid = 1'b1;
    din = 36'h5_5555_5555;
    repeat (5) begin
      @(negedge clock);
      chk("idle_din_ready", 64'(din_ready), 64'(0));
    end
    din_valid = 1'b0;
    chk("idle_no_write", 64'(weCycles - w0), 64'(0));

    // Zero length: immediate done with sticky err.
    w0 = weCycles;
    doLoad(1'b0, 5, 0, 1'b0, errSeen);
    chk("t5_err", 64'(errSeen), 64'(1));
    chk("t5_err_sticky", 64'(err), 64'(1));
    chk("t5_no_write", 64'(weCycles - w0), 64'(0));

    // Single word; accepting it clears err.
    words[0] = 36'h0_1234_5678;
    doLoad(1'b1, 7, 1, 1'b0, errSeen);
    chk("t6_err", 64'(errSeen), 64'(0));
    chk("t6_ram", 64'(ramR[7]), 64'(36'h0_1234_5678));

    // Readback corruption on word 2 is flagged only when verify is built.
    for (int i = 0; i < 4; i++) words[i] = DATA_W'(32'hC0DE_0000 + i);
    corruptEn = 1'b1;
    corruptAddr = ADDR_W'(202);
    doLoad(1'b0, 200, 4, 1'b0, errSeen);
    chk("t7_corrupt_err", 64'(errSeen), 64'(VERIFY));
    corruptEn = 1'b0;
    doLoad(1'b0, 200, 4, 1'b0, errSeen);
    chk("t7_clean_err", 64'(errSeen), 64'(0));

    // Reset after two words of an 8-word load.
    for (int i = 0; i < 8; i++) words[i] = DATA_W'(12'h100 + i);
    d0 = doneCount;
    r0 = ramWrites;
    acceptCmd(1'b0, 0, 8);
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din = words[i];
      if (din_ready) expQ.push_back('{1'b0, ADDR_W'(i), din});
      @(negedge clock);
    end
    din_valid = 1'b0;
    #1 reset = 1'b1;
    #1 chk("reset_we_drop", 64'({weL, weR}), 64'(0));
    expQ.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t8_idle", 64'({cmd_ready, busy, din_ready}), 64'(3'b100));
    repeat (2) @(negedge clock);
    chk("t8_no_done", 64'(doneCount - d0), 64'(0));
    chk("t8_ram_writes", 64'(ramWrites - r0), 64'(2));
    chk("t8_ram_0", 64'(ramL[0]), 64'(12'h100));
    chk("t8_ram_1", 64'(ramL[1]), 64'(12'h101));
    chk("t8_ram_2_kept", 64'(ramL[2]), 64'(3));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/coef_ram_loader.md
# coef_ram_loader

Host-side writer for the dual-channel coefficient RAM. Accepts a load command (channel, start address, word count), then consumes a valid/ready stream of 36-bit coefficients and drives the RAM read/write port (`addrLrw`/`addrRrw`, `datainLrw`/`datainRrw`, `weL`/`weR`) one word per cycle. Optionally reads the block back and checks a checksum. Sits between the host/configuration interface and the coefficient RAM. The FIR datapath keeps exclusive use of the 144-bit application read port.

## Interface
- `ADDR_W`, default 14: RAM word address width (16k words per channel).
- `DATA_W`, default 36: coefficient word width.
- `clock` in 1: single clock. All logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: load command valid.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_chan` in 1: 0 = left, 1 = right.
- `cmd_addr` in ADDR_W: start word address.
- `cmd_len` in ADDR_W+1: number of words, 1..16384.
- `din_valid` in 1: coefficient word valid.
- `din_ready` out 1: high only in WRITE.
- `din` in DATA_W: coefficient word.
- `addrLrw`, `addrRrw` out ADDR_W: RAM rw addresses.
- `datainLrw`, `datainRrw` out DATA_W: RAM write data.
- `weL`, `weR` out 1: RAM write enables.
- `dataoutLrw`, `dataoutRrw` in DATA_W: RAM read data. Registered in the RAM, so valid one cycle after the address, with the address held.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a command finishes.
- `err` out 1: sticky error flag. Cleared when the next command is accepted.

## Operation
- States: IDLE, WRITE, RD_ADDR, RD_DATA, FINISH.
- IDLE → WRITE on `cmd_valid && cmd_ready`. Latches chan, addr, len. Clears checksum and `err`.
- `cmd_len == 0`: go straight to FINISH. Set `err`. No writes.
- WRITE, each `din_valid && din_ready`:
  - Register addr, `din` and we=1 on the selected channel.
  - Add `din` to a DATA_W-bit write checksum (sum mod 2^DATA_W).
  - Increment addr mod 2^ADDR_W; the address wraps from 16383 to 0.
  - Decrement the remaining count.
- With no handshake in a cycle, we=0 next cycle and addr/data hold.
- After the last word: go to RD_ADDR if verify is compiled in, else FINISH.
- Unselected channel outputs: we=0, addr=0, data=0.
- Readback (verify only):
  - Reload addr to the latched start address.
  - RD_ADDR: present the address, we=0.
  - RD_DATA: address held; add the selected `dataout*rw` to the read checksum; increment addr.
  - Next state is RD_ADDR while words remain, else FINISH.
- FINISH: `done`=1 for one cycle. Set `err` if the read checksum differs from the write checksum. Return to IDLE.
- Commands are ignored while `busy`. `cmd_ready` is low there, so there is no queuing.

## Timing
- Reset values: `cmd_ready`=0 while reset is asserted, 1 in the first cycle after release (IDLE). All other outputs are 0.
- Command accepted at edge t → `din_ready`=1 from cycle t+1.
- Word handshake at edge t → we/addr/data asserted in the cycle after t. The RAM writes it at edge t+1.
- Throughput: one word per cycle while `din_valid` stays high.
- Last write handshake at edge t → we=0 after t+1. RD_ADDR begins in the cycle after t+1. Readback takes 2 cycles per word.
- `done` asserts in the cycle after the final write (no verify) or after the final RD_DATA (verify).
- Reset asserted mid-command:
  - we drops immediately (asynchronous), even within a cycle.
  - Words already written stay in RAM. No further writes.
  - FSM returns to IDLE. `done` is not pulsed.
- `din_valid` held high in IDLE is not consumed.

## Configuration
- `COEF_RAM_LOADER_VERIFY_EN` defined:
  - Readback states and both checksums are built.
  - `err` reports checksum mismatch or zero length.
- Not defined:
  - RD_ADDR/RD_DATA and both checksums are removed. WRITE goes straight to FINISH.
  - `err` reports zero length only.
  - `dataoutLrw`/`dataoutRrw` are unused.

## Test plan
- Left load, addr=0, len=4, words 0x1,0x2,0x3,0x4 with continuous `din_valid` → `weL` high 4 consecutive cycles at addrs 0..3. `weR` never high. `done` pulses, `err`=0. Application read at addrL=0 returns {1,2,3,4}.
- Right load, addr=16382, len=4 → writes land at 16382, 16383, 0, 1 (wrap). Only `weR` is asserted.
- `din_valid` toggled every other cycle, len=3 → exactly 3 write cycles, none while idle. Data order preserved.
- Verify build: RAM model forced to corrupt one bit of word 2 on readback → `done` pulses with `err`=1. Uncorrupted rerun gives `err`=0.
- `cmd_len`=0 → no we, `done` the cycle after accept, `err`=1.
- Reset after word 2 of a len=8 load → we=0 immediately. After release: IDLE, `cmd_ready`=1, only addrs 0..1 were written.
